sd_fifo_arbiter: RTL and testbench
==================================

# sd_fifo_arbiter

Arbitrates the SD controller's byte-wide data FIFO port (rd_en/rd_dat, wr_en/wr_dat) between two requesters: requester 0 is the SPI link state machine, requester 1 is the FPGA-side audio streaming engine. It replaces the static SPI/FPGA mux select with sector-granular grants. An owner keeps the FIFO until exactly BLOCK_BYTES transfers complete, it withdraws its request, or, optionally, a stall watchdog fires. It sits between the two requesters and sdc_controller.

## Interface
Parameters:
- BLOCK_BYTES, 512, byte strobes per grant (one SD sector)
- CNT_W, 10, byte counter width; must hold BLOCK_BYTES-1
- TIMEOUT_CYCLES, 65535, stall limit for the watchdog (used only with SD_ARB_TIMEOUT_EN)
- FIXED_PRIO, 0, 0 = round-robin, 1 = requester 1 (audio) always wins ties

Ports:
- clk  in  1  system clock; all logic is single-clock
- rst  in  1  synchronous reset, active-high
- req0_i / req1_i  in  1  requests ownership; held high for the whole sector
- gnt0_o / gnt1_o  out  1  grant, registered, one-hot or zero
- rd_en0_i / rd_en1_i  in  1  FIFO read strobe from the requester
- rd_dat0_o / rd_dat1_o  out  8  read data to the requester
- wr_en0_i / wr_en1_i  in  1  FIFO write strobe from the requester
- wr_dat0_i / wr_dat1_i  in  8  write data from the requester
- done0_o / done1_o  out  1  one-cycle pulse on sector completion
- rd_en_o  out  1  read strobe to sdc_controller
- rd_dat_i  in  8  read data from sdc_controller
- wr_en_o  out  1  write strobe to sdc_controller
- wr_dat_o  out  8  write data to sdc_controller
- owner_o  out  1  index of the current or last owner
- busy_o  out  1  high in BUSY
- timeout_o  out  1  sticky watchdog flag

## Operation
- States: IDLE, BUSY, GAP.
- IDLE
  - With no request, stay in IDLE.
  - With one request, grant that requester.
  - With both requests: if FIXED_PRIO=0, grant the requester that is not owner_o; if FIXED_PRIO=1, grant requester 1.
  - On a grant, go to BUSY, set cnt=0, set owner_o, and assert the gnt bit.
- BUSY
  - Only the owner's strobes and write data are forwarded. The non-owner's strobes are dropped, and its rd_dat is 0.
  - Each cycle with rd_en_o or wr_en_o high increments cnt by one. A cycle with both strobes high counts once.
  - A strobe while cnt==BLOCK_BYTES-1 ends the sector: the owner's done pulses, gnt drops, next state is GAP.
  - If the owner's req is low at a clock edge, the sector is aborted: gnt drops, done is not pulsed, next state is GAP. A strobe arriving in that same cycle is still forwarded, because gating is on gnt.
- GAP: one cycle with all grants low, then IDLE. This gives the FIFO one cycle to settle between owners.
- Reset (including mid-sector)
  - Outputs: state=IDLE, gnt0_o=gnt1_o=0, done0_o=done1_o=0, cnt=0, busy_o=0, timeout_o=0.
  - owner_o resets to 1, so requester 0 wins the first tie under round-robin.
  - A reset mid-sector produces no done pulse.

## Timing
- A request sampled at edge N gives a grant high during cycle N+1. From IDLE to first strobe the minimum latency is 1 cycle.
- Strobe and data forwarding is combinational on gnt_o: 0-cycle latency. rd_dat_i reaches the owner with the sdc_controller's own timing.
- done asserts in the cycle after the last strobe, together with gnt falling and the entry into GAP.
- Back-to-back sectors: minimum 2 cycles with no grant between the last strobe and the next gnt.
- When gnt is low, rd_en_o and wr_en_o are 0 and wr_dat_o is 0.

## Configuration
- SD_ARB_TIMEOUT_EN defined:
  - A stall counter clears on every forwarded strobe and on entry to BUSY, and increments each BUSY cycle without a strobe.
  - When it reaches TIMEOUT_CYCLES, the grant is revoked as an abort: GAP, no done.
  - timeout_o is then set and stays high until rst.
- SD_ARB_TIMEOUT_EN undefined:
  - There is no stall counter.
  - timeout_o is tied to 0.
  - A grant is held indefinitely while req stays high.

## Structure
- Shared package sd_arb_pkg:
  - state encodings ST_IDLE/ST_BUSY/ST_GAP
  - requester IDs REQ_SPI=0, REQ_FPGA=1
  - default BLOCK_BYTES
- One sub-module, sd_arb_watchdog: the stall counter and sticky flag, instantiated only under SD_ARB_TIMEOUT_EN.
- The datapath mux stays inline in sd_fifo_arbiter.

## Test plan
- Single sector: req0 held, 512 rd_en0 pulses. Expected: gnt0 one cycle after req, rd_en_o mirrors rd_en0, done0 pulses after the 512th strobe, 1 GAP cycle follows.
- Contention after reset: req0 and req1 rise in the same cycle with FIXED_PRIO=0. Expected: gnt0 first; after its sector, gnt1 follows 2 cycles after the last strobe; the next tie goes to requester 0.
- Non-owner isolation: gnt0 active, wr_en1=1 with wr_dat1=8'hA5. Expected: wr_en_o=0, cnt unchanged, rd_dat1_o=0.
- Abort: req1 drops after 100 strobes. Expected: gnt1 falls on the next edge, no done1, cnt restarts at 0 on the next grant.
- Reset mid-sector: rst pulsed at cnt=300. Expected: all outputs return to reset values next cycle, owner_o=1, no done.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner makes no strobes for 16 cycles. Expected: gnt drops, timeout_o=1 and sticky, a new request is still granted.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD data-FIFO arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic REQ_SPI  = 1'b0;
  localparam logic REQ_FPGA = 1'b1;

  localparam int BLOCK_BYTES_DEF = 512;

  // Ties go to requester 1 under fixed priority, otherwise to whoever did not own last.
  function automatic logic pick_owner(input logic r0, input logic r1,
                                      input logic last, input logic fixed_prio);
    logic sel;
    if (r0 && r1) begin
      sel = fixed_prio ? REQ_FPGA : ~last;
    end else if (r1) begin
      sel = REQ_FPGA;
    end else begin
      sel = REQ_SPI;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sd_fifo_arbiter_if.sv
// Requester and sdc_controller FIFO port bundle; slave = arbiter side, master = environment side.
interface sd_fifo_arbiter_if;
  logic       req0_i;
  logic       req1_i;
  logic       gnt0_o;
  logic       gnt1_o;
  logic       rd_en0_i;
  logic       rd_en1_i;
  logic [7:0] rd_dat0_o;
  logic [7:0] rd_dat1_o;
  logic       wr_en0_i;
  logic       wr_en1_i;
  logic [7:0] wr_dat0_i;
  logic [7:0] wr_dat1_i;
  logic       done0_o;
  logic       done1_o;
  logic       rd_en_o;
  logic [7:0] rd_dat_i;
  logic       wr_en_o;
  logic [7:0] wr_dat_o;
  logic       owner_o;
  logic       busy_o;
  logic       timeout_o;

  modport slave (
    input  req0_i, req1_i, rd_en0_i, rd_en1_i, wr_en0_i, wr_en1_i,
           wr_dat0_i, wr_dat1_i, rd_dat_i,
    output gnt0_o, gnt1_o, rd_dat0_o, rd_dat1_o, done0_o, done1_o,
           rd_en_o, wr_en_o, wr_dat_o, owner_o, busy_o, timeout_o
  );

  modport master (
    output req0_i, req1_i, rd_en0_i, rd_en1_i, wr_en0_i, wr_en1_i,
           wr_dat0_i, wr_dat1_i, rd_dat_i,
    input  gnt0_o, gnt1_o, rd_dat0_o, rd_dat1_o, done0_o, done1_o,
           rd_en_o, wr_en_o, wr_dat_o, owner_o, busy_o, timeout_o
  );
endinterface

// File: rtl/sd_arb_watchdog.sv
// Stall watchdog: counts BUSY cycles without a forwarded strobe; fire is combinational on the
// last allowed stall cycle, timeout is a sticky registered flag cleared only by rst.
module sd_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic strobe,
  output logic fire,
  output logic timeout
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] stall;

  assign fire = busy && !strobe && (stall == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall   <= '0;
      timeout <= 1'b0;
    end else begin
      // Held at zero outside BUSY so every new grant starts a fresh stall window.
      if (!busy || strobe || fire) begin
        stall <= '0;
      end else begin
        stall <= stall + W'(1);
      end
      if (fire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_fifo_arbiter.sv
// Sector-granular owner arbitration of the SD data FIFO; grant 1 cycle after request, strobes/data forwarded combinationally.
// Optional stall watchdog under SD_ARB_TIMEOUT_EN; non-owner strobes are dropped, no backpressure is generated.
module sd_fifo_arbiter
  import sd_arb_pkg::*;
#(
  parameter int BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int CNT_W          = 10,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FIXED_PRIO     = 0
) (
  input logic              clk,
  input logic              rst,
  sd_fifo_arbiter_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;

  logic rd_en;
  logic wr_en;
  logic strobe;
  logic busy;
  logic owner_req;
  logic next_owner;
  logic last_byte;
  logic wd_fire;

  // Gating is purely on the registered grants, so a strobe in the abort cycle still passes.
  assign rd_en  = (gnt0 & bus.rd_en0_i) | (gnt1 & bus.rd_en1_i);
  assign wr_en  = (gnt0 & bus.wr_en0_i) | (gnt1 & bus.wr_en1_i);
  assign strobe = rd_en | wr_en;
  assign busy   = (state == ST_BUSY);

  assign bus.rd_en_o   = rd_en;
  assign bus.wr_en_o   = wr_en;
  assign bus.wr_dat_o  = gnt0 ? bus.wr_dat0_i : (gnt1 ? bus.wr_dat1_i : 8'h00);
  assign bus.rd_dat0_o = gnt0 ? bus.rd_dat_i : 8'h00;
  assign bus.rd_dat1_o = gnt1 ? bus.rd_dat_i : 8'h00;
  assign bus.gnt0_o    = gnt0;
  assign bus.gnt1_o    = gnt1;
  assign bus.done0_o   = done0;
  assign bus.done1_o   = done1;
  assign bus.owner_o   = owner;
  assign bus.busy_o    = busy;

  assign owner_req  = owner ? bus.req1_i : bus.req0_i;
  assign next_owner = pick_owner(bus.req0_i, bus.req1_i, owner, FIXED_PRIO != 0);
  assign last_byte  = (cnt == CNT_W'(BLOCK_BYTES - 1));

`ifdef SD_ARB_TIMEOUT_EN
  logic wd_timeout;

  sd_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .strobe (strobe),
    .fire   (wd_fire),
    .timeout(wd_timeout)
  );

  assign bus.timeout_o = wd_timeout;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_fire            = 1'b0;
  assign bus.timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      owner <= REQ_FPGA;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req0_i || bus.req1_i) begin
            owner <= next_owner;
            gnt0  <= (next_owner == REQ_SPI);
            gnt1  <= (next_owner == REQ_FPGA);
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Abort wins over completion: a withdrawn request never earns a done pulse.
          if (!owner_req || wd_fire) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= ST_GAP;
          end else if (strobe) begin
            if (last_byte) begin
              done0 <= (owner == REQ_SPI);
              done1 <= (owner == REQ_FPGA);
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              cnt   <= '0;
              state <= ST_GAP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_fifo_arbiter.sv
// Directed bench for sd_fifo_arbiter: stimulus queues expected grant/done/abort events, a monitor checks them.
module tb_sd_fifo_arbiter;

  localparam int NB = 512;
  localparam int TO = 16;
  localparam int K_GNT   = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int kind;
    int id;
    int info;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_fifo_arbiter_if bus();

  sd_fifo_arbiter #(
    .BLOCK_BYTES   (NB),
    .CNT_W         (10),
    .TIMEOUT_CYCLES(TO),
    .FIXED_PRIO    (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  ev_t  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int id, input int info);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.info = info;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int id, input int info);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event_unexpected: got kind=%0d id=%0d info=%0d, want none (cycle %0d)",
               kind, id, info, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.id != id || (e.info != -1 && e.info != info)) begin
        bad++;
        $display("FAIL event: got kind=%0d id=%0d info=%0d, want kind=%0d id=%0d info=%0d (cycle %0d)",
                 kind, id, info, e.kind, e.id, e.info, cyc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: grant rise, done pulse, grant fall without done; info = strobes in sector or gap cycles.
  initial begin
    logic pg0, pg1;
    int   sc, last_strobe;
    pg0 = 1'b0;
    pg1 = 1'b0;
    sc = 0;
    last_strobe = -100;
    forever begin
      @(negedge clk);
      if (pg0 && !bus.gnt0_o) begin
        got(bus.done0_o ? K_DONE : K_ABORT, 0, sc);
        sc = 0;
      end else if (bus.done0_o) begin
        got(K_DONE, 0, -99);
      end
      if (pg1 && !bus.gnt1_o) begin
        got(bus.done1_o ? K_DONE : K_ABORT, 1, sc);
        sc = 0;
      end else if (bus.done1_o) begin
        got(K_DONE, 1, -99);
      end
      if (!pg0 && bus.gnt0_o) begin
        got(K_GNT, 0, cyc - last_strobe);
        sc = 0;
      end
      if (!pg1 && bus.gnt1_o) begin
        got(K_GNT, 1, cyc - last_strobe);
        sc = 0;
      end
      if (bus.rd_en_o || bus.wr_en_o) begin
        sc++;
        last_strobe = cyc;
      end
      pg0 = bus.gnt0_o;
      pg1 = bus.gnt1_o;
    end
  end

  task automatic clear_strobes();
    bus.rd_en0_i  = 1'b0;
    bus.rd_en1_i  = 1'b0;
    bus.wr_en0_i  = 1'b0;
    bus.wr_en1_i  = 1'b0;
    bus.wr_dat0_i = 8'h00;
    bus.wr_dat1_i = 8'h00;
    bus.rd_dat_i  = 8'h00;
  endtask

  // n consecutive strobe cycles from requester id; ends one cycle after the last strobe.
  task automatic strobes(input int id, input int n, input bit use_wr);
    for (int i = 0; i < n; i++) begin
      logic [7:0] rd_v, wr_v;
      logic       wr_on;
      rd_v  = 8'(i) ^ 8'h5A;
      wr_v  = 8'(i) ^ 8'hC3;
      wr_on = use_wr & i[0];
      tick();
      bus.rd_dat_i = rd_v;
      if (id == 0) begin
        bus.rd_en0_i  = 1'b1;
        bus.wr_en0_i  = wr_on;
        bus.wr_dat0_i = wr_v;
      end else begin
        bus.rd_en1_i  = 1'b1;
        bus.wr_en1_i  = wr_on;
        bus.wr_dat1_i = wr_v;
      end
      at_neg();
      if (i % 128 == 0 || i == n - 1) begin
        chk("fwd_rd_en", bus.rd_en_o, 1);
        chk("fwd_rd_dat", (id == 0) ? bus.rd_dat0_o : bus.rd_dat1_o, rd_v);
        chk("fwd_wr_en", bus.wr_en_o, wr_on);
        chk("fwd_wr_dat", bus.wr_dat_o, wr_v);
        chk("no_early_done", bus.done0_o | bus.done1_o, 0);
      end
    end
    tick();
    clear_strobes();
  endtask

  initial begin
    #300000;
    $display("FAIL sim_time_limit: got timeout, want completion");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
    clear_strobes();
    rst = 1'b1;
    repeat (2) tick();
    at_neg();
    chk("rst_gnt0", bus.gnt0_o, 0);
    chk("rst_gnt1", bus.gnt1_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", {bus.done1_o, bus.done0_o}, 0);
    chk("rst_owner", bus.owner_o, 1);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_strobes", {bus.rd_en_o, bus.wr_en_o}, 0);
    chk("rst_wr_dat", bus.wr_dat_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single sector from requester 0.
    expect_ev(K_GNT, 0, -1);
    expect_ev(K_DONE, 0, NB);
    bus.req0_i = 1'b1;
    tick();
    at_neg();
    chk("t1_gnt0", bus.gnt0_o, 1);
    chk("t1_gnt1", bus.gnt1_o, 0);
    chk("t1_owner", bus.owner_o, 0);
    chk("t1_busy", bus.busy_o, 1);
    strobes(0, NB, 0);
    bus.req0_i = 1'b0;
    at_neg();
    chk("t1_done0", bus.done0_o, 1);
    chk("t1_gnt_fall", bus.gnt0_o, 0);
    chk("t1_gap_busy", bus.busy_o, 0);
    tick();
    at_neg();
    chk("t1_done_once", bus.done0_o, 0);
    chk("t1_idle_gnt", bus.gnt0_o, 0);

    // Reset mid-sector at cnt=300.
    expect_ev(K_GNT, 0, -1);
    expect_ev(K_ABORT, 0, 300);
    bus.req0_i = 1'b1;
    strobes(0, 300, 0);
    rst = 1'b1;
    bus.req0_i = 1'b0;
    tick();
    at_neg();
    chk("t5_gnt0", bus.gnt0_o, 0);
    chk("t5_owner", bus.owner_o, 1);
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_done", {bus.done1_o, bus.done0_o}, 0);
    chk("t5_rd_en", bus.rd_en_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Contention after reset, plus non-owner isolation.
    expect_ev(K_GNT, 0, -1);
    bus.req0_i = 1'b1;
    bus.req1_i = 1'b1;
    tick();
    at_neg();
    chk("t2_tie_gnt0", bus.gnt0_o, 1);
    chk("t2_tie_gnt1", bus.gnt1_o, 0);
    tick();
    bus.wr_en1_i  = 1'b1;
    bus.wr_dat1_i = 8'hA5;
    bus.rd_en1_i  = 1'b1;
    bus.wr_dat0_i = 8'h3C;
    bus.rd_dat_i  = 8'hFF;
    at_neg();
    chk("t3_wr_en", bus.wr_en_o, 0);
    chk("t3_rd_en", bus.rd_en_o, 0);
    chk("t3_wr_dat", bus.wr_dat_o, 8'h3C);
    chk("t3_rd_dat1", bus.rd_dat1_o, 0);
    chk("t3_rd_dat0", bus.rd_dat0_o, 8'hFF);
    tick();
    clear_strobes();
    expect_ev(K_DONE, 0, NB);
    expect_ev(K_GNT, 1, 3);
    strobes(0, NB, 1);
    bus.req0_i = 1'b0;
    at_neg();
    chk("t2_done0", bus.done0_o, 1);
    tick();
    at_neg();
    chk("t2_gap_gnt1", bus.gnt1_o, 0);
    tick();
    at_neg();
    chk("t2_gnt1", bus.gnt1_o, 1);
    chk("t2_owner", bus.owner_o, 1);

    // Abort of requester 1 after 100 strobes; strobe in the abort cycle still forwarded.
    expect_ev(K_ABORT, 1, 101);
    strobes(1, 100, 0);
    bus.req1_i   = 1'b0;
    bus.rd_en1_i = 1'b1;
    at_neg();
    chk("t4_abort_fwd", bus.rd_en_o, 1);
    tick();
    bus.rd_en1_i = 1'b0;
    bus.req0_i   = 1'b1;
    bus.req1_i   = 1'b1;
    at_neg();
    chk("t4_gnt1_fall", bus.gnt1_o, 0);
    chk("t4_no_done1", bus.done1_o, 0);
    chk("t4_busy", bus.busy_o, 0);

    // Next tie goes to requester 0; full sector proves the count restarted.
    expect_ev(K_GNT, 0, 3);
    expect_ev(K_DONE, 0, NB);
    tick();
    tick();
    at_neg();
    chk("t6_tie_gnt0", bus.gnt0_o, 1);
    chk("t6_tie_gnt1", bus.gnt1_o, 0);
    strobes(0, NB, 1);
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
    at_neg();
    chk("t6_done0", bus.done0_o, 1);
    tick();
    tick();
    at_neg();
    chk("t6_no_regrant", {bus.gnt1_o, bus.gnt0_o}, 0);

`ifdef SD_ARB_TIMEOUT_EN
    // Stalled owner is revoked after TO strobe-less cycles.
    expect_ev(K_GNT, 0, -1);
    expect_ev(K_ABORT, 0, 0);
    bus.req0_i = 1'b1;
    tick();
    at_neg();
    chk("to_gnt0", bus.gnt0_o, 1);
    repeat (TO - 1) tick();
    at_neg();
    chk("to_still_gnt", bus.gnt0_o, 1);
    chk("to_not_yet", bus.timeout_o, 0);
    tick();
    bus.req0_i = 1'b0;
    at_neg();
    chk("to_revoked", bus.gnt0_o, 0);
    chk("to_flag", bus.timeout_o, 1);
    chk("to_no_done", bus.done0_o, 0);
    expect_ev(K_GNT, 1, -1);
    expect_ev(K_ABORT, 1, 0);
    tick();
    bus.req1_i = 1'b1;
    tick();
    at_neg();
    chk("to_regrant", bus.gnt1_o, 1);
    chk("to_sticky", bus.timeout_o, 1);
    bus.req1_i = 1'b0;
    tick();
    at_neg();
    chk("to_release", bus.gnt1_o, 0);
    chk("to_sticky2", bus.timeout_o, 1);
`else
    // Without the watchdog a stalled owner keeps the grant.
    expect_ev(K_GNT, 0, -1);
    expect_ev(K_ABORT, 0, 0);
    bus.req0_i = 1'b1;
    tick();
    repeat (2 * TO) tick();
    at_neg();
    chk("hold_gnt0", bus.gnt0_o, 1);
    chk("hold_busy", bus.busy_o, 1);
    chk("hold_timeout", bus.timeout_o, 0);
    bus.req0_i = 1'b0;
    tick();
    at_neg();
    chk("hold_release", bus.gnt0_o, 0);
`endif

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
